// File: rtl/l1d_miss_controller_pkg.sv
// Geometry, address field layout, FSM encoding and access-size checking for the L1D controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package l1d_miss_controller_pkg;

    localparam int ADDR_W     = 64;
    localparam int SETS       = 64;
    localparam int WAYS       = 8;
    localparam int LINE_BYTES = 64;
    localparam int TAG_W      = 24;
    localparam int IDX_W      = 6;
    localparam int OFF_W      = 6;
    localparam int WAY_W      = 3;
    localparam int PLRU_W     = 7;
    localparam int TAG_LSB    = IDX_W + OFF_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_RESPOND   = 3'd2,
        S_WB_RD     = 3'd3,
        S_WB_REQ    = 3'd4,
        S_FILL_REQ  = 3'd5,
        S_FILL_WAIT = 3'd6,
        S_INVAL     = 3'd7
    } state_t;

    // Size codes 4..7 are illegal; legal accesses may not run past the end of the line.
    function automatic logic access_err(input logic [OFF_W-1:0] off, input logic [2:0] size);
        logic [7:0] bytes;
        logic [7:0] last;
        bytes = 8'd1 << size[1:0];
        last  = {2'b00, off} + bytes;
        return size[2] | (last > 8'(LINE_BYTES));
    endfunction

endpackage

// File: rtl/l1d_miss_controller_if.sv
// CPU request/response, data-bank steering and lower-level request signals of the L1D controller.
// Latency: none (wiring only).
// Backpressure: cpu_req_ready and low_req_ready gate their respective valids.
interface l1d_miss_controller_if;
    import l1d_miss_controller_pkg::*;

    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_we;
    logic              cpu_clf;
    logic [ADDR_W-1:0] cpu_addr;
    logic [2:0]        cpu_size;
    logic              cpu_resp_valid;
    logic              cpu_resp_hit;
    logic              cpu_resp_err;
    logic              dary_en;
    logic              dary_we;
    logic              dary_fill_sel;
    logic [IDX_W-1:0]  dary_set;
    logic [WAY_W-1:0]  dary_way;
    logic              low_req_valid;
    logic              low_req_ready;
    logic              low_req_we;
    logic [ADDR_W-1:0] low_req_addr;
    logic              low_resp_valid;

    // Environment side: CPU and lower level.
    modport master (
        output cpu_req_valid, cpu_we, cpu_clf, cpu_addr, cpu_size, low_req_ready, low_resp_valid,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_hit, cpu_resp_err,
               dary_en, dary_we, dary_fill_sel, dary_set, dary_way,
               low_req_valid, low_req_we, low_req_addr
    );

    // Controller side.
    modport slave (
        input  cpu_req_valid, cpu_we, cpu_clf, cpu_addr, cpu_size, low_req_ready, low_resp_valid,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_hit, cpu_resp_err,
               dary_en, dary_we, dary_fill_sel, dary_set, dary_way,
               low_req_valid, low_req_we, low_req_addr
    );
endinterface

// File: rtl/l1d_miss_controller_plru8.sv
// Per-set 3-level tree pseudo-LRU for 8 ways: victim select and touch update.
// Latency: victim is combinational from rd_set_i; touch takes effect on the next clock edge.
// Backpressure: none; a touch is accepted every cycle it is strobed.
module l1d_miss_controller_plru8
    import l1d_miss_controller_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_set_i,
    output logic [WAY_W-1:0] victim_way_o,
    input  logic             touch_i,
    input  logic [IDX_W-1:0] touch_set_i,
    input  logic [WAY_W-1:0] touch_way_i
);
    // Tree bits point toward the victim: [0] root, [1]/[2] half nodes, [3..6] leaf pairs.
    logic [PLRU_W-1:0] tree_q [SETS];
    logic [PLRU_W-1:0] rd_tree;
    logic [PLRU_W-1:0] tree_d;
    logic              vic_hi;
    logic              vic_mid;
    logic              vic_lo;

    // Follow the pointer bits from the root to the least-recently-used way.
    always_comb begin
        rd_tree = tree_q[rd_set_i];
        vic_hi  = rd_tree[0];
        vic_mid = vic_hi ? rd_tree[2] : rd_tree[1];
        case ({vic_hi, vic_mid})
            2'b00:   vic_lo = rd_tree[3];
            2'b01:   vic_lo = rd_tree[4];
            2'b10:   vic_lo = rd_tree[5];
            default: vic_lo = rd_tree[6];
        endcase
        victim_way_o = {vic_hi, vic_mid, vic_lo};
    end

    // Point every node on the touched way's path away from it.
    always_comb begin
        tree_d    = tree_q[touch_set_i];
        tree_d[0] = ~touch_way_i[2];
        if (touch_way_i[2]) tree_d[2] = ~touch_way_i[1];
        else                tree_d[1] = ~touch_way_i[1];
        case (touch_way_i[2:1])
            2'b00:   tree_d[3] = ~touch_way_i[0];
            2'b01:   tree_d[4] = ~touch_way_i[0];
            2'b10:   tree_d[5] = ~touch_way_i[0];
            default: tree_d[6] = ~touch_way_i[0];
        endcase
    end

    // Tree state storage, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
        end else if (touch_i) begin
            tree_q[touch_set_i] <= tree_d;
        end
    end

endmodule

// File: rtl/l1d_miss_controller.sv
// L1D sequencer: tag/valid/dirty ownership, hit/miss resolution, victim writeback and refill.
// Latency: hit 2 cycles accept->resp; miss adds writeback/refill states plus lower-level waits.
// Backpressure: one request in flight (ready only in IDLE); lower request held until low_req_ready.
module l1d_miss_controller
    import l1d_miss_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    l1d_miss_controller_if.slave bus
);
    state_t            state_q, state_d;
    logic [TAG_W-1:0]  req_tag_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic              req_we_q, req_clf_q, req_err_q, resp_hit_q, first_q;
    logic [WAY_W-1:0]  vic_way_q;
    logic [TAG_W-1:0]  vic_tag_q;

    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];

    logic [WAYS-1:0]   hit_vec;
    logic              hit, has_inv;
    logic [WAY_W-1:0]  hit_way, inv_way, plru_way, vic_way;
    logic              touch;
    logic [WAY_W-1:0]  touch_way;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^bus.cpu_addr[ADDR_W-1:TAG_LSB+TAG_W];

    l1d_miss_controller_plru8 u_plru (
        .clk          (clk),
        .rst          (rst),
        .rd_set_i     (req_idx_q),
        .victim_way_o (plru_way),
        .touch_i      (touch),
        .touch_set_i  (req_idx_q),
        .touch_way_i  (touch_way)
    );

    // Tag compare across the indexed set; victim prefers the lowest invalid way over PLRU.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        inv_way = '0;
        has_inv = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q);
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid_q[req_idx_q][w]) begin
                inv_way = WAY_W'(w);
                has_inv = 1'b1;
            end
        end
        hit     = |hit_vec;
        vic_way = has_inv ? inv_way : plru_way;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and all outputs, decoded from the current state.
    always_comb begin
        state_d            = state_q;
        bus.cpu_req_ready  = 1'b0;
        bus.cpu_resp_valid = 1'b0;
        bus.cpu_resp_hit   = 1'b0;
        bus.cpu_resp_err   = 1'b0;
        bus.dary_en        = 1'b0;
        bus.dary_we        = 1'b0;
        bus.dary_fill_sel  = 1'b0;
        bus.dary_set       = req_idx_q;
        bus.dary_way       = vic_way_q;
        bus.low_req_valid  = 1'b0;
        bus.low_req_we     = 1'b0;
        bus.low_req_addr   = '0;
        touch              = 1'b0;
        touch_way          = vic_way_q;
        case (state_q)
            S_IDLE: begin
                bus.cpu_req_ready = 1'b1;
                if (bus.cpu_req_valid)
                    state_d = access_err(bus.cpu_addr[OFF_W-1:0], bus.cpu_size) ? S_RESPOND : S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit && !req_clf_q) begin
                    bus.dary_en  = 1'b1;
                    bus.dary_we  = req_we_q;
                    bus.dary_way = hit_way;
                    touch        = 1'b1;
                    touch_way    = hit_way;
                    state_d      = S_RESPOND;
                end else if (hit) begin
                    state_d = dirty_q[req_idx_q][hit_way] ? S_WB_RD : S_INVAL;
                end else if (req_clf_q) begin
                    state_d = S_RESPOND;
                end else begin
                    state_d = dirty_q[req_idx_q][vic_way] ? S_WB_RD : S_FILL_REQ;
                end
            end
            S_WB_RD: begin
                bus.dary_en = 1'b1;
                state_d     = S_WB_REQ;
            end
            S_WB_REQ: begin
                bus.low_req_valid = 1'b1;
                bus.low_req_we    = 1'b1;
                bus.low_req_addr  = {{(ADDR_W-TAG_LSB-TAG_W){1'b0}}, vic_tag_q, req_idx_q, {OFF_W{1'b0}}};
                if (bus.low_req_ready) state_d = req_clf_q ? S_INVAL : S_FILL_REQ;
            end
            S_FILL_REQ: begin
                bus.low_req_valid = 1'b1;
                bus.low_req_addr  = {{(ADDR_W-TAG_LSB-TAG_W){1'b0}}, req_tag_q, req_idx_q, {OFF_W{1'b0}}};
                if (bus.low_req_ready) state_d = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (bus.low_resp_valid) begin
                    bus.dary_en       = 1'b1;
                    bus.dary_we       = 1'b1;
                    bus.dary_fill_sel = 1'b1;
                    touch             = 1'b1;
                    state_d           = S_LOOKUP;
                end
            end
            S_INVAL: state_d = S_RESPOND;
            default: begin
                bus.cpu_resp_valid = 1'b1;
                bus.cpu_resp_hit   = resp_hit_q;
                bus.cpu_resp_err   = req_err_q;
                state_d            = S_IDLE;
            end
        endcase
    end

    // Request capture, victim bookkeeping and tag/valid/dirty array maintenance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_tag_q  <= '0;
            req_idx_q  <= '0;
            req_we_q   <= 1'b0;
            req_clf_q  <= 1'b0;
            req_err_q  <= 1'b0;
            resp_hit_q <= 1'b0;
            first_q    <= 1'b0;
            vic_way_q  <= '0;
            vic_tag_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: if (bus.cpu_req_valid) begin
                    req_tag_q  <= bus.cpu_addr[TAG_LSB +: TAG_W];
                    req_idx_q  <= bus.cpu_addr[OFF_W +: IDX_W];
                    req_we_q   <= bus.cpu_we;
                    req_clf_q  <= bus.cpu_clf;
                    req_err_q  <= access_err(bus.cpu_addr[OFF_W-1:0], bus.cpu_size);
                    resp_hit_q <= 1'b0;
                    first_q    <= 1'b1;
                end
                S_LOOKUP: begin
                    first_q <= 1'b0;
                    if (first_q) resp_hit_q <= hit;
                    if (hit) begin
                        vic_way_q <= hit_way;
                        vic_tag_q <= req_tag_q;
                        if (req_we_q && !req_clf_q) dirty_q[req_idx_q][hit_way] <= 1'b1;
                    end else begin
                        vic_way_q <= vic_way;
                        vic_tag_q <= tag_q[req_idx_q][vic_way];
                    end
                end
                S_WB_REQ: if (bus.low_req_ready) dirty_q[req_idx_q][vic_way_q] <= 1'b0;
                S_FILL_WAIT: if (bus.low_resp_valid) begin
                    tag_q[req_idx_q][vic_way_q]   <= req_tag_q;
                    valid_q[req_idx_q][vic_way_q] <= 1'b1;
                    dirty_q[req_idx_q][vic_way_q] <= 1'b0;
                end
                S_INVAL: begin
                    valid_q[req_idx_q][vic_way_q] <= 1'b0;
                    dirty_q[req_idx_q][vic_way_q] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
